// File: rtl/prog_clk_div_multi.sv
// prog_clk_div_multi: multi-channel programmable square-wave divider.
// Each channel divides clk by 2*(act+1). Writes are held in a shadow register
// and only take effect at a toggle boundary (or immediately when the channel
// is disabled), so a running tone never sees a truncated half-cycle.
//
// Write interface: wr_en is a single-cycle strobe with no backpressure. Every
// cycle with wr_en=1 is accepted; a write whose wr_addr has no matching channel
// (wr_addr >= CHANNELS) is dropped. The last write to a channel before its
// apply point is the one that gets applied. The design expects
// 2**ADDR_W >= CHANNELS.
module prog_clk_div_multi #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 24,
  parameter int ADDR_W   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic [CHANNELS-1:0] en,
  output logic [CHANNELS-1:0] div_clk,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] pend
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] act_q;
    logic [WIDTH-1:0] shadow_q;
    logic             pend_q;
    logic             div_q;
    logic             rise_q;
    logic             wr_hit;
    logic             at_boundary;

    // Address decode: an out-of-range address never matches any channel.
    assign wr_hit      = wr_en && (wr_addr == ADDR_W'(i));
    // The >= form only guards against cnt ever overshooting act.
    assign at_boundary = (cnt_q >= act_q);

    // Per-channel counter, output phase, shadow period and apply logic.
    always_ff @(posedge clk) begin
      if (!rst) begin
        cnt_q    <= '0;
        act_q    <= '0;
        shadow_q <= '0;
        pend_q   <= 1'b0;
        div_q    <= 1'b0;
        rise_q   <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        if (!en[i]) begin
          // Idle channel: hold phase at zero and take any pending period now.
          cnt_q <= '0;
          div_q <= 1'b0;
          if (pend_q) begin
            act_q  <= shadow_q;
            pend_q <= 1'b0;
          end
        end else if (at_boundary) begin
          div_q  <= ~div_q;
          rise_q <= ~div_q;
          cnt_q  <= '0;
          if (pend_q) begin
            act_q  <= shadow_q;
            pend_q <= 1'b0;
          end
        end else begin
          cnt_q <= cnt_q + WIDTH'(1);
        end
        // Placed last so a write on an apply edge re-arms pend: the apply
        // above has already consumed the old shadow value.
        if (wr_hit) begin
          shadow_q <= wr_data;
          pend_q   <= 1'b1;
        end
      end
    end

    assign div_clk[i]    = div_q;
    assign rise_pulse[i] = rise_q;
    assign pend[i]       = pend_q;
  end

endmodule

// File: tb/tb_prog_clk_div_multi.sv
// Bench for prog_clk_div_multi: a default 4-channel/24-bit instance and a
// reduced 3-channel/4-bit instance, both checked every cycle against a
// toggle-schedule reference model, plus directed timing checks.
module tb_prog_clk_div_multi;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [23:0] wr_data;
  logic [3:0]  en;
  logic [3:0]  div_clk, rise_pulse, pend;

  logic        s_wr_en;
  logic [1:0]  s_wr_addr;
  logic [3:0]  s_wr_data;
  logic [2:0]  s_en;
  logic [2:0]  s_div_clk, s_rise_pulse, s_pend;

  prog_clk_div_multi #(.CHANNELS(4), .WIDTH(24), .ADDR_W(2)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .en(en), .div_clk(div_clk), .rise_pulse(rise_pulse), .pend(pend)
  );

  prog_clk_div_multi #(.CHANNELS(3), .WIDTH(4), .ADDR_W(2)) dut_s (
    .clk(clk), .rst(rst), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .en(s_en), .div_clk(s_div_clk), .rise_pulse(s_rise_pulse), .pend(s_pend)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int t       = 0;   // absolute posedge number

  // Reference model: each running channel has an absolute edge number at
  // which its next toggle is due; toggles reschedule by (period+1) edges.
  int m_act  [2][4];
  int m_sh   [2][4];
  int m_next [2][4];
  bit m_pend [2][4];
  bit m_lvl  [2][4];
  bit m_rise [2][4];
  bit m_run  [2][4];

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [31:0] rise_q[$];

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int d, input int nch, input bit r, input bit we,
                            input int wa, input int wd, input logic [3:0] e);
    for (int c = 0; c < nch; c++) begin
      if (!r) begin
        m_act[d][c] = 0; m_sh[d][c] = 0; m_pend[d][c] = 0;
        m_lvl[d][c] = 0; m_rise[d][c] = 0; m_run[d][c] = 0; m_next[d][c] = 0;
      end else begin
        m_rise[d][c] = 0;
        if (!e[c]) begin
          m_lvl[d][c] = 0;
          m_run[d][c] = 0;
          if (m_pend[d][c]) begin m_act[d][c] = m_sh[d][c]; m_pend[d][c] = 0; end
        end else begin
          if (!m_run[d][c]) begin
            m_run[d][c]  = 1;
            m_next[d][c] = t + m_act[d][c];
          end
          if (t == m_next[d][c]) begin
            m_lvl[d][c]  = !m_lvl[d][c];
            m_rise[d][c] = m_lvl[d][c];
            if (m_pend[d][c]) begin m_act[d][c] = m_sh[d][c]; m_pend[d][c] = 0; end
            m_next[d][c] = t + m_act[d][c] + 1;
          end
        end
        if (we && wa == c) begin m_sh[d][c] = wd; m_pend[d][c] = 1; end
      end
    end
  endtask

  task automatic check_all();
    logic [3:0] ed, er, ep;
    logic [2:0] sd, sr, sp;
    for (int c = 0; c < 4; c++) begin
      ed[c] = m_lvl[0][c]; er[c] = m_rise[0][c]; ep[c] = m_pend[0][c];
    end
    for (int c = 0; c < 3; c++) begin
      sd[c] = m_lvl[1][c]; sr[c] = m_rise[1][c]; sp[c] = m_pend[1][c];
    end
    chk("div_clk", div_clk, ed);
    chk("rise_pulse", rise_pulse, er);
    chk("pend", pend, ep);
    chk("s_div_clk", s_div_clk, sd);
    chk("s_rise_pulse", s_rise_pulse, sr);
    chk("s_pend", s_pend, sp);
  endtask

  // ---------------- driver tasks ----------------
  // Inputs are changed at negedge; one call = one posedge plus full check.
  task automatic tick();
    bit r, we, swe;
    int wa, wd, swa, swd;
    logic [3:0] e, se;
    r = rst; we = wr_en; wa = int'(wr_addr); wd = int'(wr_data); e = en;
    swe = s_wr_en; swa = int'(s_wr_addr); swd = int'(s_wr_data); se = {1'b0, s_en};
    @(posedge clk);
    t++;
    model_step(0, 4, r, we, wa, wd, e);
    model_step(1, 3, r, swe, swa, swd, se);
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic write_main(input int a, input int v);
    wr_en = 1'b1; wr_addr = 2'(a); wr_data = 24'(v);
    tick();
    wr_en = 1'b0;
  endtask

  // Runs n edges, logging (edge - base) of each div_clk change and rise pulse.
  task automatic collect(input int d, input int ch, input int n, input int base);
    logic prev, cur, rp;
    got_q.delete(); rise_q.delete();
    prev = (d == 0) ? div_clk[ch] : s_div_clk[ch];
    for (int k = 0; k < n; k++) begin
      tick();
      cur = (d == 0) ? div_clk[ch] : s_div_clk[ch];
      rp  = (d == 0) ? rise_pulse[ch] : s_rise_pulse[ch];
      if (cur !== prev) got_q.push_back(32'(t - base));
      if (rp === 1'b1) rise_q.push_back(32'(t - base));
      prev = cur;
    end
  endtask

  task automatic compare_q(input string tag, input bit use_rise);
    int n;
    if (use_rise) begin
      chk({tag, "_count"}, 32'(rise_q.size()), 32'(exp_q.size()));
      n = (rise_q.size() < exp_q.size()) ? rise_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) chk(tag, rise_q[i], exp_q[i]);
    end else begin
      chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) chk(tag, got_q[i], exp_q[i]);
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int base;
    int b;
    rst = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; en = '0;
    s_wr_en = 1'b0; s_wr_addr = '0; s_wr_data = '0; s_en = '0;

    // Reset held for three edges.
    repeat (3) tick();
    chk("reset_div", div_clk, 0);
    chk("reset_pend", pend, 0);
    chk("reset_rise", rise_pulse, 0);
    rst = 1'b1;

    // Basic divide, ch0 P=3: rises at 4,12,20; falls at 8,16.
    write_main(0, 3);
    tick();
    chk("ch0_applied_pend", pend[0], 0);
    en[0] = 1'b1; base = t;
    collect(0, 0, 20, base);
    exp_q = '{4, 8, 12, 16, 20};
    compare_q("ch0_toggles", 1'b0);
    exp_q = '{4, 12, 20};
    compare_q("ch0_rises", 1'b1);

    // Glitch-free update on ch1: P=9 running, P=2 written mid half-period.
    write_main(1, 9);
    tick();
    en[1] = 1'b1; base = t;
    repeat (5) tick();
    write_main(1, 2);
    chk("ch1_pend_held", pend[1], 1);
    collect(0, 1, 10, base);
    exp_q = '{10, 13, 16};
    compare_q("ch1_toggles", 1'b0);

    // Apply and write on the same edge for ch0.
    write_main(0, 1);
    for (int k = 0; k < 20 && (t + 1) < m_next[0][0]; k++) tick();
    write_main(0, 5);
    chk("collide_pend", pend[0], 1);
    base = t;
    collect(0, 0, 10, base);
    exp_q = '{2, 8};
    compare_q("collide_toggles", 1'b0);

    // Disable mid high phase, write while disabled, restart from phase 0.
    write_main(2, 4);
    tick();
    en[2] = 1'b1;
    repeat (7) tick();
    chk("ch2_high", div_clk[2], 1);
    en[2] = 1'b0;
    tick();
    chk("ch2_dropped", div_clk[2], 0);
    write_main(2, 6);
    chk("ch2_pend_set", pend[2], 1);
    tick();
    chk("ch2_pend_clear", pend[2], 0);
    en[2] = 1'b1; base = t;
    collect(0, 2, 8, base);
    exp_q = '{7};
    compare_q("ch2_restart_rise", 1'b1);

    // P=0: toggle every clk.
    en[3] = 1'b1; base = t;
    collect(0, 3, 4, base);
    exp_q = '{1, 2, 3, 4};
    compare_q("ch3_p0", 1'b0);

    // Reduced build: max period 15 gives 16-clk half-periods.
    s_wr_en = 1'b1; s_wr_addr = 2'd0; s_wr_data = 4'd15;
    tick();
    s_wr_en = 1'b0;
    tick();
    s_en[0] = 1'b1; base = t;
    collect(1, 0, 34, base);
    exp_q = '{16, 32};
    compare_q("s_pmax", 1'b0);
    // Out-of-range address on the 3-channel build is ignored.
    s_wr_en = 1'b1; s_wr_addr = 2'd3; s_wr_data = 4'd5;
    tick();
    s_wr_en = 1'b0;
    chk("s_oob_pend", s_pend, 0);

    // Randomised traffic on both instances.
    for (int k = 0; k < 400; k++) begin
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = 2'($urandom_range(0, 3));
      wr_data = 24'($urandom_range(0, 12));
      if ($urandom_range(0, 7) == 0) begin b = $urandom_range(0, 3); en[b] = ~en[b]; end
      s_wr_en   = ($urandom_range(0, 3) == 0);
      s_wr_addr = 2'($urandom_range(0, 3));
      s_wr_data = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) begin b = $urandom_range(0, 2); s_en[b] = ~s_en[b]; end
      tick();
    end
    wr_en = 1'b0; s_wr_en = 1'b0;

    // Reset mid-operation with pends set and a write in flight.
    en = 4'hF; s_en = 3'h7;
    for (int c = 0; c < 4; c++) write_main(c, $urandom_range(1, 5));
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 24'd7;
    s_wr_en = 1'b1; s_wr_addr = 2'd1; s_wr_data = 4'd9;
    rst = 1'b0;
    tick();
    chk("rst_mid_div", div_clk, 0);
    chk("rst_mid_pend", pend, 0);
    chk("rst_mid_rise", rise_pulse, 0);
    chk("rst_mid_s_div", s_div_clk, 0);
    chk("rst_mid_s_pend", s_pend, 0);
    rst = 1'b1; wr_en = 1'b0; s_wr_en = 1'b0; en = 4'b1000; s_en = '0;
    base = t;
    collect(0, 3, 4, base);
    exp_q = '{1, 2, 3, 4};
    compare_q("rst_act0_toggles", 1'b0);

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
